// File: rtl/ppu_fb_bank.sv
// Double-buffered PPU framebuffer slice: the PPU draws into the back buffer while the
// display reads the front buffer; buffers swap on the first frame_start after frame_done.
module ppu_fb_bank #(
    parameter int unsigned COLOR_WIDTH = 16,
    parameter int unsigned DEPTH       = 48000,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [COLOR_WIDTH-1:0] wr_data,
    output logic                   wr_ready,
    input  logic                   frame_done,
    input  logic                   frame_start,
    input  logic [ADDR_W-1:0]      raddress,
    output logic [COLOR_WIDTH-1:0] rdata,
    output logic                   front_sel,
    output logic                   swap_done,
    output logic [7:0]             frame_count,
    output logic                   wr_overrun
);

    if (COLOR_WIDTH == 0 || COLOR_WIDTH > 30) begin : g_bad_color_width
        $error("ppu_fb_bank: COLOR_WIDTH must be in 1..30");
    end
    if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
        $error("ppu_fb_bank: ADDR_W too narrow for DEPTH");
    end

    typedef enum logic [1:0] {
        StDraw,
        StPending,
        StSwap
    } state_e;

    state_e                   state_q, state_d;
    logic                     front_sel_q, front_sel_d;
    logic                     swap_done_q, swap_done_d;
    logic                     wr_ready_q, wr_ready_d;
    logic                     wr_overrun_q, wr_overrun_d;
    logic [7:0]               frame_count_q, frame_count_d;
    logic [COLOR_WIDTH-1:0]   rdata_q, rdata_d;

    logic [COLOR_WIDTH-1:0]   buf0_mem [DEPTH];
    logic [COLOR_WIDTH-1:0]   buf1_mem [DEPTH];

    logic                     wr_in_range;
    logic                     rd_in_range;
    logic                     wr_fire;

    assign wr_in_range = (32'(wr_addr) < DEPTH);
    assign rd_in_range = (32'(raddress) < DEPTH);
    // wr_ready_q is high exactly when the FSM sits in StDraw.
    assign wr_fire     = wr_en && wr_ready_q && wr_in_range;

    always_comb begin
        state_d       = state_q;
        front_sel_d   = front_sel_q;
        frame_count_d = frame_count_q;
        wr_overrun_d  = wr_overrun_q;

        unique case (state_q)
            StDraw: begin
                // A frame_start coinciding with frame_done is deliberately not honoured.
                if (frame_done) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (frame_start) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                state_d       = StDraw;
                front_sel_d   = ~front_sel_q;
                frame_count_d = frame_count_q + 8'd1;
            end
            default: begin
                state_d = StDraw;
            end
        endcase

        // Out-of-range addresses are silently discarded, even while the back buffer is locked.
        if (wr_en && !wr_ready_q && wr_in_range) begin
            wr_overrun_d = 1'b1;
        end

        wr_ready_d  = (state_d == StDraw);
        swap_done_d = (state_d == StSwap);
    end

    always_comb begin
        rdata_d = '0;
        if (rd_in_range) begin
            rdata_d = front_sel_q ? buf1_mem[raddress] : buf0_mem[raddress];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StDraw;
            front_sel_q   <= 1'b0;
            swap_done_q   <= 1'b0;
            wr_ready_q    <= 1'b1;
            wr_overrun_q  <= 1'b0;
            frame_count_q <= 8'd0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            front_sel_q   <= front_sel_d;
            swap_done_q   <= swap_done_d;
            wr_ready_q    <= wr_ready_d;
            wr_overrun_q  <= wr_overrun_d;
            frame_count_q <= frame_count_d;
            rdata_q       <= rdata_d;
        end
    end

    // Pixel storage is never reset; writes always target the buffer not being displayed.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            if (front_sel_q) begin
                buf0_mem[wr_addr] <= wr_data;
            end else begin
                buf1_mem[wr_addr] <= wr_data;
            end
        end
    end

    assign wr_ready    = wr_ready_q;
    assign rdata       = rdata_q;
    assign front_sel   = front_sel_q;
    assign swap_done   = swap_done_q;
    assign frame_count = frame_count_q;
    assign wr_overrun  = wr_overrun_q;

endmodule

// File: tb/tb_ppu_fb_bank.sv
// Directed bench for ppu_fb_bank: a transaction-level model is compared every cycle,
// and hand-computed literal checks pin the key scenarios.
module tb_ppu_fb_bank;

    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 48000;
    localparam int unsigned AW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          wr_ready;
    logic          frame_done;
    logic          frame_start;
    logic [AW-1:0] raddress;
    logic [CW-1:0] rdata;
    logic          front_sel;
    logic          swap_done;
    logic [7:0]    frame_count;
    logic          wr_overrun;

    int n_vec = 0;
    int n_err = 0;

    ppu_fb_bank #(
        .COLOR_WIDTH(CW),
        .DEPTH      (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .frame_done (frame_done),
        .frame_start(frame_start),
        .raddress   (raddress),
        .rdata      (rdata),
        .front_sel  (front_sel),
        .swap_done  (swap_done),
        .frame_count(frame_count),
        .wr_overrun (wr_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: "locked" means a finished frame awaits display; "swapping" is the swap cycle.
    bit            chk_en = 1'b0;
    bit            m_locked, m_swapping, m_front, m_ovr, m_rd_known;
    int            m_cnt;
    logic [CW-1:0] m_rd;
    logic [CW-1:0] m_mem [int];

    always @(posedge clk) begin
        if (rst) begin
            chk_en     = 1'b1;
            m_locked   = 1'b0;
            m_swapping = 1'b0;
            m_front    = 1'b0;
            m_ovr      = 1'b0;
            m_cnt      = 0;
            m_rd_known = 1'b1;
            m_rd       = '0;
        end else if (chk_en) begin
            int rkey;
            int wkey;
            bit can_write;
            rkey = int'(m_front) * 65536 + int'(raddress);
            if (int'(raddress) >= int'(DEPTH)) begin
                m_rd_known = 1'b1;
                m_rd       = '0;
            end else if (m_mem.exists(rkey)) begin
                m_rd_known = 1'b1;
                m_rd       = m_mem[rkey];
            end else begin
                m_rd_known = 1'b0;
            end
            can_write = !m_locked && !m_swapping;
            if (wr_en && int'(wr_addr) < int'(DEPTH)) begin
                if (can_write) begin
                    wkey = int'(!m_front) * 65536 + int'(wr_addr);
                    m_mem[wkey] = wr_data;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (m_swapping) begin
                m_swapping = 1'b0;
                m_front    = !m_front;
                m_cnt      = (m_cnt + 1) % 256;
            end else if (m_locked) begin
                if (frame_start) begin
                    m_locked   = 1'b0;
                    m_swapping = 1'b1;
                end
            end else if (frame_done) begin
                m_locked = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_wr_ready", wr_ready, !(m_locked || m_swapping));
            check("model_front_sel", front_sel, m_front);
            check("model_swap_done", swap_done, m_swapping);
            check("model_frame_count", frame_count, m_cnt);
            check("model_wr_overrun", wr_overrun, m_ovr);
            if (m_rd_known) check("model_rdata", rdata, m_rd);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        frame_done = 1'b0; frame_start = 1'b0; raddress = '0;
        cyc(2);
        check("rst_rdata", rdata, 0);
        check("rst_front_sel", front_sel, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_wr_overrun", wr_overrun, 0);
        check("rst_swap_done", swap_done, 0);
        rst = 1'b0;

        // Basic write, frame_done, frame_start, read back after swap.
        wr_en = 1'b1; wr_addr = 16'd5; wr_data = 16'hABCD; cyc(1); wr_en = 1'b0;
        frame_done = 1'b1; cyc(1); frame_done = 1'b0;
        check("pending_wr_ready", wr_ready, 0);
        cyc(2);
        frame_start = 1'b1; cyc(1); frame_start = 1'b0;
        check("swap_pulse", swap_done, 1);
        check("swap_front_old", front_sel, 0);
        raddress = 16'd5; cyc(1);
        check("swap_pulse_end", swap_done, 0);
        check("swap_front_new", front_sel, 1);
        check("swap_count", frame_count, 1);
        cyc(1);
        check("swap_rdata", rdata, 16'hABCD);
        wr_en = 1'b1; wr_addr = 16'd5; wr_data = 16'h1234; cyc(1); wr_en = 1'b0;
        check("front_untouched", rdata, 16'hABCD);

        // Write while locked: dropped, sticky overrun until reset.
        frame_done = 1'b1; cyc(1); frame_done = 1'b0;
        wr_en = 1'b1; wr_addr = 16'd3; wr_data = 16'h5555; cyc(1); wr_en = 1'b0;
        check("ovr_wr_ready", wr_ready, 0);
        check("ovr_set", wr_overrun, 1);
        cyc(3);
        frame_start = 1'b1; cyc(1); frame_start = 1'b0;
        cyc(2);
        check("ovr_sticky", wr_overrun, 1);
        check("ovr_rdata_buf0", rdata, 16'h1234);
        check("ovr_count", frame_count, 2);
        rst = 1'b1; cyc(1); rst = 1'b0;
        check("ovr_cleared", wr_overrun, 0);

        // frame_done and frame_start together: only the later frame_start swaps.
        frame_done = 1'b1; frame_start = 1'b1; cyc(1);
        frame_done = 1'b0; frame_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("same_cycle_no_swap", swap_done, 0);
            cyc(1);
        end
        frame_start = 1'b1; cyc(1); frame_start = 1'b0;
        check("late_swap_pulse", swap_done, 1);
        cyc(1);
        check("late_swap_count", frame_count, 1);

        // Out-of-range read and write.
        raddress = 16'(DEPTH); wr_en = 1'b1; wr_addr = 16'(DEPTH); wr_data = 16'hFFFF;
        cyc(1); wr_en = 1'b0;
        check("oor_rdata", rdata, 0);
        check("oor_no_overrun", wr_overrun, 0);
        raddress = 16'hFFFF; cyc(1);
        check("oor_rdata_max", rdata, 0);

        // Reset while pending, with other inputs active during reset.
        frame_done = 1'b1; cyc(1); frame_done = 1'b0;
        rst = 1'b1; wr_en = 1'b1; wr_addr = 16'd7; frame_done = 1'b1; frame_start = 1'b1;
        cyc(1);
        rst = 1'b0; wr_en = 1'b0; frame_done = 1'b0; frame_start = 1'b0;
        check("rstpend_wr_ready", wr_ready, 1);
        check("rstpend_front", front_sel, 0);
        frame_start = 1'b1; cyc(1); frame_start = 1'b0; cyc(2);
        frame_start = 1'b1; cyc(1); frame_start = 1'b0; cyc(2);
        check("rstpend_no_swap_front", front_sel, 0);
        check("rstpend_no_swap_count", frame_count, 0);

        // 256 full frames; writes coincide with frame_done.
        for (int i = 0; i < 256; i++) begin
            wr_en = 1'b1; wr_addr = 16'(i % 8); wr_data = 16'(i * 16'h0101);
            frame_done = 1'b1; raddress = 16'((i + 3) % 8);
            cyc(1);
            wr_en = 1'b0; frame_done = 1'b0;
            cyc(1);
            frame_start = 1'b1; cyc(1); frame_start = 1'b0;
            cyc(1);
            if (i == 127) check("wrap_half_count", frame_count, 128);
        end
        check("wrap_count", frame_count, 0);
        check("wrap_front", front_sel, 0);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ppu_fb_bank.md
PPU_FB_BANK -- requirements
Module: ppu_fb_bank

Interface
- REQ-001 Parameter COLOR_WIDTH, default 16, pixel word width; SHALL be at most 30.
- REQ-002 Parameter DEPTH, default 48000, pixels per buffer (one core's slice: 800*600/10).
- REQ-003 Parameter ADDR_W, default 16, address width; SHALL satisfy 2^ADDR_W >= DEPTH.
- REQ-004 clk  in  1  single clock for the whole block (GPU clock domain).
- REQ-005 rst  in  1  reset, synchronous, active-high.
- REQ-006 wr_en  in  1  PPU pixel write strobe.
- REQ-007 wr_addr  in  ADDR_W  PPU pixel write address.
- REQ-008 wr_data  in  COLOR_WIDTH  PPU pixel colour.
- REQ-009 wr_ready  out  1  high when back buffer accepts writes.
- REQ-010 frame_done  in  1  one-cycle pulse: PPU finished rendering the back buffer.
- REQ-011 frame_start  in  1  one-cycle pulse from display side when its read address wraps to 0.
- REQ-012 raddress  in  ADDR_W  display read address.
- REQ-013 rdata  out  COLOR_WIDTH  display read data from front buffer.
- REQ-014 front_sel  out  1  index (0/1) of buffer currently displayed.
- REQ-015 swap_done  out  1  one-cycle pulse when buffers swap.
- REQ-016 frame_count  out  8  number of completed swaps, modulo 256.
- REQ-017 wr_overrun  out  1  sticky flag: write attempted while wr_ready low.

Function
- REQ-018 Block SHALL hold two DEPTH x COLOR_WIDTH buffers; front = front_sel, back = !front_sel.
- REQ-019 Read: rdata SHALL equal front[raddress] one clk after raddress is sampled, using front_sel as of the sampling cycle.
- REQ-020 Read with raddress >= DEPTH SHALL return 0 one cycle later.
- REQ-021 Write: wr_en high and wr_ready high SHALL write wr_data to back[wr_addr] at that clk edge.
- REQ-022 Write with wr_addr >= DEPTH SHALL be dropped without setting wr_overrun.
- REQ-023 FSM states DRAW, PENDING, SWAP; wr_ready SHALL be 1 only in DRAW.
- REQ-024 DRAW -> PENDING on frame_done; otherwise stay.
- REQ-025 PENDING -> SWAP on frame_start; frame_done in PENDING SHALL be ignored.
- REQ-026 SWAP lasts exactly one cycle: front_sel SHALL toggle at its exit edge, swap_done high during SWAP, frame_count +1 (255 wraps to 0), then -> DRAW.
- REQ-027 frame_done and frame_start in the same DRAW cycle: go to PENDING; that frame_start is not honoured, swap waits for the next frame_start.
- REQ-028 frame_start in DRAW or SWAP SHALL have no effect.
- REQ-029 wr_en high while wr_ready low SHALL drop the write and set wr_overrun; it clears only on rst.
- REQ-030 Write in the same cycle as frame_done (state DRAW) SHALL be accepted.
- REQ-031 Swap latency: frame_start in PENDING at cycle N -> swap_done high in N+1, new front_sel visible from N+2.

Reset
- REQ-032 On rst high at a clk edge: state DRAW, front_sel 0, swap_done 0, frame_count 0, wr_overrun 0, rdata 0.
- REQ-033 rst mid-PENDING or SWAP SHALL abandon the pending swap; buffer contents are not cleared and undefined after power-up.
- REQ-034 Inputs other than rst SHALL be ignored in any cycle where rst is high.

Verification
- REQ-035 Reset, write back[5]=16'hABCD, frame_done, frame_start, read raddress=5 -> swap_done pulses once, front_sel=1, rdata=16'hABCD one cycle after address, frame_count=1.
- REQ-036 frame_done, then wr_en with wr_addr=3 before frame_start -> write dropped, wr_ready=0, wr_overrun=1 until rst.
- REQ-037 frame_done and frame_start same cycle -> no swap; second frame_start 10 cycles later -> swap_done exactly then +1.
- REQ-038 256 full swap cycles -> frame_count returns to 0, front_sel back to 0.
- REQ-039 raddress=DEPTH and wr_addr=DEPTH -> rdata=0, no memory change, wr_overrun stays 0.
- REQ-040 rst asserted while PENDING -> state DRAW, wr_ready=1, front_sel=0, later frame_start causes no swap.
